// File: rtl/vigenere_decryptor_stream.sv
// Streaming Vigenere decryptor over the 49-symbol alphabet '*'..'Z' with a loadable repeating key.
// Optional feature macro: VIG_DEC_PASSTHRU_EN (out-of-range bytes pass through without consuming key).
module vigenere_decryptor_stream #(
  parameter int MAX_KEY_LEN = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       key_clear,
  input  logic       key_wr,
  input  logic [7:0] key_char,
  input  logic       key_last,
  output logic       key_err,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] cipher_char,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] plain_char,
  output logic       out_err
);

  localparam int LW = $clog2(MAX_KEY_LEN + 1);
  localparam int IW = $clog2(MAX_KEY_LEN);

  typedef enum logic [1:0] {S_NOKEY, S_LOAD, S_RUN} state_t;

  state_t        state, state_nx;
  logic [7:0]    key_buf [MAX_KEY_LEN];
  logic [LW-1:0] key_len;
  logic [IW-1:0] key_idx;
  logic [IW-1:0] idx_next;
  logic [7:0]    key_cur;
  logic          key_ok, key_full, key_store, key_rej;
  logic          accept, c_in_range;
  logic [5:0]    c_off, k_off;
  logic [6:0]    diff, diff_adj;
  logic [7:0]    dec_char;

  assign key_ok     = (key_char >= 8'h2A) && (key_char <= 8'h5A);
  assign c_in_range = (cipher_char >= 8'h2A) && (cipher_char <= 8'h5A);
  assign key_full   = (key_len == LW'(MAX_KEY_LEN));
  assign in_ready   = (state == S_RUN) && !key_clear && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_NOKEY;
    else     state <= state_nx;
  end

  // key_clear wins over any key write in the same cycle, so it never raises key_err
  always_comb begin
    state_nx  = state;
    key_store = 1'b0;
    key_rej   = 1'b0;
    if (key_clear) begin
      state_nx = S_LOAD;
    end else begin
      case (state)
        S_NOKEY: key_rej = key_wr;
        S_LOAD: begin
          if (key_wr) begin
            if (key_ok && !key_full) begin
              key_store = 1'b1;
              if (key_last) state_nx = S_RUN;
            end else begin
              key_rej = 1'b1;
            end
          end
        end
        S_RUN:   key_rej = key_wr;
        default: state_nx = S_NOKEY;
      endcase
    end
  end

  assign key_cur  = key_buf[key_idx];
  assign c_off    = 6'(cipher_char - 8'h2A);
  assign k_off    = 6'(key_cur - 8'h2A);
  assign diff     = {1'b0, c_off} - {1'b0, k_off};
  assign diff_adj = diff[6] ? diff + 7'd49 : diff;
  assign dec_char = {1'b0, diff_adj} + 8'h2A;
  assign idx_next = (key_idx == IW'(key_len - LW'(1))) ? '0 : key_idx + IW'(1);

  always_ff @(posedge clk) begin
    if (key_store) key_buf[IW'(key_len)] <= key_char;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      key_len    <= '0;
      key_idx    <= '0;
      out_valid  <= 1'b0;
      plain_char <= 8'h00;
      out_err    <= 1'b0;
      key_err    <= 1'b0;
    end else begin
      key_err <= key_rej;
      if (key_clear) begin
        key_len   <= '0;
        key_idx   <= '0;
        out_valid <= 1'b0;
      end else begin
        if (key_store) begin
          key_len <= key_len + LW'(1);
          if (key_last) key_idx <= '0;
        end
        if (accept) begin
          out_valid <= 1'b1;
          if (c_in_range) begin
            plain_char <= dec_char;
            out_err    <= 1'b0;
            key_idx    <= idx_next;
          end else begin
`ifdef VIG_DEC_PASSTHRU_EN
            plain_char <= cipher_char;
            out_err    <= 1'b0;
`else
            plain_char <= 8'h00;
            out_err    <= 1'b1;
            key_idx    <= idx_next;
`endif
          end
        end else if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_vigenere_decryptor_stream.sv
// Self-checking bench for vigenere_decryptor_stream: vector table, directed corner cases, randomized model check.
module tb_vigenere_decryptor_stream;

  logic       clk = 1'b0;
  logic       rst, key_clear, key_wr, key_last, in_valid, out_ready;
  logic [7:0] key_char, cipher_char;
  logic       key_err, in_ready, out_valid, out_err;
  logic [7:0] plain_char;

  int n_cmp = 0;
  int n_fail = 0;

  vigenere_decryptor_stream #(.MAX_KEY_LEN(16)) dut (
    .clk(clk), .rst(rst), .key_clear(key_clear), .key_wr(key_wr), .key_char(key_char),
    .key_last(key_last), .key_err(key_err), .in_valid(in_valid), .in_ready(in_ready),
    .cipher_char(cipher_char), .out_valid(out_valid), .out_ready(out_ready),
    .plain_char(plain_char), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] key;
    logic [7:0] c;
    logic [7:0] p;
  } vec_t;

  vec_t vt[6];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    key_clear = 1'b1;
    tick();
    key_clear = 1'b0;
  endtask

  task automatic key_write(input logic [7:0] k, input logic last);
    key_wr = 1'b1; key_char = k; key_last = last;
    tick();
    key_wr = 1'b0; key_last = 1'b0;
  endtask

  task automatic load_key(input string s);
    for (int i = 0; i < s.len(); i++) key_write(s[i], (i == s.len() - 1));
  endtask

  function automatic int dec(input int c, input int k);
    return ((c - 42) - (k - 42) + 49) % 49 + 42;
  endfunction

  // reference model state for the randomized phase
  logic [7:0] mk[$];
  int  mi;
  bit  mv;
  int  mp, me;

  initial begin
    string hello_c, hello_p;
    rst = 1'b1; key_clear = 0; key_wr = 0; key_char = 0; key_last = 0;
    in_valid = 0; cipher_char = 0; out_ready = 1;

    vt[0] = '{8'h2B, 8'h2A, 8'h5A};   // '+' , '*' -> 'Z'
    vt[1] = '{8'h5A, 8'h5A, 8'h2A};   // 'Z' , 'Z' -> '*'
    vt[2] = '{8'h2A, 8'h4D, 8'h4D};   // '*' , 'M' -> 'M'
    vt[3] = '{8'h41, 8'h41, 8'h2A};   // 'A' , 'A' -> '*'
    vt[4] = '{8'h42, 8'h2A, 8'h43};   // 'B' , '*' -> 'C'
    vt[5] = '{8'h2A, 8'h5A, 8'h5A};   // '*' , 'Z' -> 'Z'

    tick(); tick();
    check("rst_out_valid", out_valid, 0);
    check("rst_plain", plain_char, 8'h00);
    check("rst_out_err", out_err, 0);
    check("rst_key_err", key_err, 0);
    check("rst_in_ready", in_ready, 0);
    rst = 1'b0;
    tick();

    // key write with no key loaded
    key_write("A", 1'b1);
    check("nokey_key_err", key_err, 1);
    tick();
    check("nokey_key_err_drop", key_err, 0);
    check("nokey_in_ready", in_ready, 0);

    // basic decrypt
    do_clear();
    load_key("KEY");
    check("run_in_ready_next", in_ready, 1);
    hello_c = "8/J<9"; hello_p = "HELLO";
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; cipher_char = hello_c[i];
      tick();
      check("hello_valid", out_valid, 1);
      check("hello_char", plain_char, hello_p[i]);
    end
    in_valid = 1'b0;
    tick();
    check("hello_drain", out_valid, 0);

    // single-character key edge arithmetic
    for (int i = 0; i < 6; i++) begin
      do_clear();
      key_write(vt[i].key, 1'b1);
      in_valid = 1'b1; cipher_char = vt[i].c;
      tick();
      in_valid = 1'b0;
      check("vec_valid", out_valid, 1);
      check("vec_char", plain_char, vt[i].p);
      check("vec_err", out_err, 0);
    end
    tick();

    // backpressure
    do_clear();
    load_key("KEY");
    out_ready = 1'b0; in_valid = 1'b1; cipher_char = "8";
    tick();
    cipher_char = "/";
    #1;
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_char", plain_char, "H");
      check("bp_hold_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("bp_next_char", plain_char, "E");
    tick();

    // key load errors
    do_clear();
    key_write("A", 1'b0);
    check("load_ok_err", key_err, 0);
    key_write(8'h20, 1'b0);
    check("load_space_err", key_err, 1);
    key_write("Z", 1'b1);
    check("load_after_err", key_err, 0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; cipher_char = "A";
      tick();
      check("space_keylen_char", plain_char, dec("A", (i % 2 == 0) ? "A" : "Z"));
    end
    in_valid = 1'b0;
    tick();

    do_clear();
    for (int i = 0; i < 16; i++) begin
      key_write(8'h2A + 8'(i), 1'b0);
      check("fill_err", key_err, 0);
    end
    key_write("Q", 1'b0);
    check("overflow_err", key_err, 1);
    key_write("Q", 1'b1);
    check("overflow_last_err", key_err, 1);
    check("overflow_still_load", in_ready, 0);

    // mid-stream clear
    do_clear();
    load_key("KEY");
    out_ready = 1'b0; in_valid = 1'b1; cipher_char = "8";
    tick();
    check("mc_pending", out_valid, 1);
    key_clear = 1'b1; cipher_char = "/";
    #1;
    check("mc_not_ready", in_ready, 0);
    tick();
    key_clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("mc_dropped", out_valid, 0);
    key_write("K", 1'b1);
    check("mc_load_state_err", key_err, 0);
    check("mc_run_ready", in_ready, 1);

    // out-of-range input
    do_clear();
    load_key("KEY");
    hello_c = "8 /";
    in_valid = 1'b1; cipher_char = hello_c[0];
    tick();
    check("oor_0", plain_char, "H");
    cipher_char = hello_c[1];
    tick();
`ifdef VIG_DEC_PASSTHRU_EN
    check("oor_1_char", plain_char, " ");
    check("oor_1_err", out_err, 0);
    cipher_char = hello_c[2];
    tick();
    check("oor_2_char", plain_char, "E");
`else
    check("oor_1_char", plain_char, 8'h00);
    check("oor_1_err", out_err, 1);
    cipher_char = hello_c[2];
    tick();
    check("oor_2_char", plain_char, dec("/", "Y"));
    check("oor_2_err", out_err, 0);
`endif
    in_valid = 1'b0;
    tick();

    // randomized stream against reference model
    do_clear();
    mk.delete();
    begin
      int klen = $urandom_range(1, 16);
      for (int i = 0; i < klen; i++) mk.push_back(8'($urandom_range(42, 90)));
      for (int i = 0; i < klen; i++) key_write(mk[i], (i == klen - 1));
    end
    mi = 0; mv = 0; mp = 0; me = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      bit acc, exp_rdy;
      int c;
      in_valid    = ($urandom_range(0, 3) != 0);
      out_ready   = ($urandom_range(0, 3) != 0);
      c           = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 255) : $urandom_range(42, 90);
      cipher_char = 8'(c);
      #1;
      exp_rdy = !mv || out_ready;
      check("rnd_in_ready", in_ready, exp_rdy);
      acc = in_valid && exp_rdy;
      tick();
      if (acc) begin
        mv = 1;
        if (c >= 42 && c <= 90) begin
          mp = dec(c, mk[mi]); me = 0; mi = (mi + 1) % mk.size();
        end else begin
`ifdef VIG_DEC_PASSTHRU_EN
          mp = c; me = 0;
`else
          mp = 0; me = 1; mi = (mi + 1) % mk.size();
`endif
        end
      end else if (out_ready) begin
        mv = 0;
      end
      check("rnd_out_valid", out_valid, mv);
      if (mv) begin
        check("rnd_plain", plain_char, mp);
        check("rnd_err", out_err, me);
      end
    end

    // reset mid-stream discards key and pending output
    in_valid = 1'b1; out_ready = 1'b0; cipher_char = "A";
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    check("rst_mid_valid", out_valid, 0);
    check("rst_mid_plain", plain_char, 8'h00);
    tick();
    check("rst_mid_nokey", in_ready, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
